// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I fetch front end: boot vector, NOP encoding,
// fetch FSM states and the {pc, instr} entry carried to decode.
package rv32i_pkg;
  localparam logic [31:0] RV_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetch entries; flush wins over push and pop in the same cycle.
// The caller only pushes when not full or when a pop happens in the same cycle.
module fetch_skid_buffer
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);
  fetch_entry_t [1:0] r_mem;
  logic               r_wr;
  logic               r_rd;
  logic [1:0]         r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, BOOT/RUN/HALTED FSM, redirect/halt handling and skid buffer to decode.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirects halt fetch and raise a sticky fault.
module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RV_RESET_VECTOR,
  parameter int          IMEM_AW      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic               fetch_fault
);
  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  w_tgt;
  logic         w_misalign;
  logic         w_push, w_pop, w_full, w_empty;
  fetch_entry_t w_head, w_entry;

  assign w_tgt = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_fault;
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault <= 1'b0;
    else if (redirect_valid && w_misalign) r_fault <= 1'b1;
  end
  assign fetch_fault = r_fault;
`else
  logic w_unused_lo;
  assign w_unused_lo = ^redirect_pc[1:0];
  assign w_misalign  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Pushing while full is fine when the head leaves in the same cycle.
  assign w_pop  = !w_empty && out_ready;
  assign w_push = (r_state == RUN) && !redirect_valid && !halt_req && (!w_full || w_pop);

  assign w_entry.pc    = r_pc;
  assign w_entry.instr = imem_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (redirect_valid) begin
      w_pc_nxt    = w_tgt;
      w_state_nxt = (halt_req || w_misalign) ? HALTED : RUN;
    end else begin
      case (r_state)
        BOOT:    w_state_nxt = RUN;
        RUN: begin
          if (halt_req)    w_state_nxt = HALTED;
          else if (w_push) w_pc_nxt    = r_pc + 32'd4;
        end
        HALTED:  w_state_nxt = HALTED;
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_addr = r_pc[IMEM_AW+1:2];
  assign out_valid = !w_empty;
  assign out_pc    = w_empty ? 32'h0 : w_head.pc;
  assign out_instr = w_empty ? NOP_INSTR : w_head.instr;
  assign halted    = (r_state == HALTED);
endmodule
